// File: rtl/pattern_tx_1100111.sv
// Serial pattern transmitter: sends PATTERN MSB first, reps times, with gap idle cycles between repetitions.
// All outputs registered; first bit appears the cycle after an accepted start.
module pattern_tx_1100111 #(
  parameter int              PLEN    = 7,
  parameter logic [PLEN-1:0] PATTERN = 7'b1100111,
  parameter int              GAPW    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [3:0]      reps,
  input  logic [GAPW-1:0] gap,
  input  logic            abort,
  output logic            out,
  output logic            valid,
  output logic            busy,
  output logic            done
);

  localparam int IW = (PLEN > 2) ? $clog2(PLEN) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(PLEN - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]      state;
  logic [IW-1:0]   idx;
  logic [3:0]      rem;
  logic [GAPW-1:0] gap_q;
  logic [GAPW-1:0] gcnt;

  // Outputs are loaded alongside the state transition, so they describe the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= '0;
      rem   <= '0;
      gap_q <= '0;
      gcnt  <= '0;
      out   <= 1'b0;
      valid <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          out   <= 1'b0;
          valid <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
          if (start) begin
            gap_q <= gap;
            rem   <= reps;
            idx   <= IDX_TOP;
            busy  <= 1'b1;
            if (reps == 4'd0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_SEND;
              out   <= PATTERN[IDX_TOP];
              valid <= 1'b1;
            end
          end
        end

        S_SEND: begin
          if (abort) begin
            state <= S_IDLE;
            idx   <= '0;
            rem   <= '0;
            gcnt  <= '0;
            out   <= 1'b0;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
          end else if (idx != '0) begin
            idx <= idx - 1'b1;
            out <= PATTERN[idx - 1'b1];
          end else if (rem > 4'd1) begin
            rem <= rem - 1'b1;
            if (gap_q != '0) begin
              state <= S_GAP;
              gcnt  <= gap_q;
              out   <= 1'b0;
              valid <= 1'b0;
            end else begin
              idx <= IDX_TOP;
              out <= PATTERN[IDX_TOP];
            end
          end else begin
            state <= S_DONE;
            rem   <= '0;
            out   <= 1'b0;
            valid <= 1'b0;
            done  <= 1'b1;
          end
        end

        S_GAP: begin
          if (abort) begin
            state <= S_IDLE;
            idx   <= '0;
            rem   <= '0;
            gcnt  <= '0;
            out   <= 1'b0;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
          end else if (gcnt > 1) begin
            gcnt <= gcnt - 1'b1;
          end else begin
            // Last gap cycle: the next repetition starts without a dead cycle.
            state <= S_SEND;
            gcnt  <= '0;
            idx   <= IDX_TOP;
            out   <= PATTERN[IDX_TOP];
            valid <= 1'b1;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          out   <= 1'b0;
          valid <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          out   <= 1'b0;
          valid <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_tx_1100111.sv
// Directed bench for pattern_tx_1100111; inputs driven and outputs sampled on the falling edge.
module tb_pattern_tx_1100111;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] reps;
  logic [3:0] gap;
  logic       abort;
  logic       out;
  logic       valid;
  logic       busy;
  logic       done;

  int n_checks;
  int n_fail;

  logic [6:0] pat;
  logic [3:0] tr [0:63];
  logic [3:0] ex [0:63];

  pattern_tx_1100111 dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .reps  (reps),
    .gap   (gap),
    .abort (abort),
    .out   (out),
    .valid (valid),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // tr[i] = {out, valid, busy, done} for the i-th cycle from the current one.
  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      tr[i] = {out, valid, busy, done};
      @(negedge clk);
    end
  endtask

  // Returns at the falling edge of the cycle following the accepting edge.
  task automatic pulse_start(input logic [3:0] r, input logic [3:0] g);
    reps  = r;
    gap   = g;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b1;
    abort = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({out, valid, busy, done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 0000", {out, valid, busy, done});
    end
    start = 1'b0;
    abort = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({out, valid, busy, done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %b expected 0000", {out, valid, busy, done});
    end
  endtask

  task automatic test_single;
    pulse_start(4'd1, 4'd0);
    capture(10);
    for (int i = 0; i < 7; i++) ex[i] = {pat[6-i], 3'b110};
    ex[7] = 4'b0011;
    ex[8] = 4'b0000;
    ex[9] = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (tr[i] !== ex[i]) begin
        n_fail++;
        $display("FAIL single_seq cycle %0d: got %b expected %b", i, tr[i], ex[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [13:0] bits;
    logic [6:0]  sh;
    int          hits;
    bits = 14'b11001111100111;
    pulse_start(4'd2, 4'd0);
    capture(16);
    for (int i = 0; i < 14; i++) ex[i] = {bits[13-i], 3'b110};
    ex[14] = 4'b0011;
    ex[15] = 4'b0000;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (tr[i] !== ex[i]) begin
        n_fail++;
        $display("FAIL b2b_seq cycle %0d: got %b expected %b", i, tr[i], ex[i]);
      end
    end
    // Loopback detector over the valid output stream.
    sh = 7'b0;
    hits = 0;
    for (int i = 0; i < 16; i++) begin
      if (tr[i][2]) begin
        sh = {sh[5:0], tr[i][3]};
        if (sh == 7'b1100111) hits++;
      end
    end
    n_checks++;
    if (hits !== 2) begin
      n_fail++;
      $display("FAIL b2b_detect: got %0d detections expected 2", hits);
    end
  endtask

  task automatic test_gap;
    int k;
    int busy_cnt;
    pulse_start(4'd3, 4'd2);
    reps = 4'd0;   // late changes must not disturb the captured values
    gap  = 4'd7;
    capture(30);
    k = 0;
    for (int r = 0; r < 3; r++) begin
      for (int b = 0; b < 7; b++) begin
        ex[k] = {pat[6-b], 3'b110};
        k++;
      end
      if (r < 2) begin
        for (int g = 0; g < 2; g++) begin
          ex[k] = 4'b0010;
          k++;
        end
      end
    end
    ex[k] = 4'b0011;
    k++;
    for (int i = k; i < 30; i++) ex[i] = 4'b0000;
    busy_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (tr[i][1]) busy_cnt++;
      n_checks++;
      if (tr[i] !== ex[i]) begin
        n_fail++;
        $display("FAIL gap_seq cycle %0d: got %b expected %b", i, tr[i], ex[i]);
      end
    end
    n_checks++;
    if (busy_cnt !== 26) begin
      n_fail++;
      $display("FAIL gap_busy_len: got %0d expected 26", busy_cnt);
    end
  endtask

  task automatic test_zero_reps;
    pulse_start(4'd0, 4'd3);
    capture(3);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (tr[i] !== ((i == 0) ? 4'b0011 : 4'b0000)) begin
        n_fail++;
        $display("FAIL zero_reps cycle %0d: got %b expected %b", i, tr[i],
                 (i == 0) ? 4'b0011 : 4'b0000);
      end
    end
  endtask

  task automatic test_abort;
    pulse_start(4'd2, 4'd0);
    repeat (3) @(negedge clk);
    n_checks++;
    if ({out, valid, busy, done} !== 4'b0110) begin
      n_fail++;
      $display("FAIL abort_pre_bit: got %b expected 0110", {out, valid, busy, done});
    end
    abort = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({out, valid, busy, done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL abort_idle: got %b expected 0000", {out, valid, busy, done});
    end
    // abort still high alongside start: start must win.
    pulse_start(4'd1, 4'd0);
    abort = 1'b0;
    capture(9);
    for (int i = 0; i < 7; i++) ex[i] = {pat[6-i], 3'b110};
    ex[7] = 4'b0011;
    ex[8] = 4'b0000;
    for (int i = 0; i < 9; i++) begin
      n_checks++;
      if (tr[i] !== ex[i]) begin
        n_fail++;
        $display("FAIL abort_restart cycle %0d: got %b expected %b", i, tr[i], ex[i]);
      end
    end
  endtask

  task automatic test_reset_midgap;
    reps  = 4'd2;
    gap   = 4'd3;
    start = 1'b1;
    @(negedge clk);
    capture(9);   // start stays high throughout and must be ignored
    for (int i = 0; i < 7; i++) ex[i] = {pat[6-i], 3'b110};
    ex[7] = 4'b0010;
    ex[8] = 4'b0010;
    for (int i = 0; i < 9; i++) begin
      n_checks++;
      if (tr[i] !== ex[i]) begin
        n_fail++;
        $display("FAIL midgap_seq cycle %0d: got %b expected %b", i, tr[i], ex[i]);
      end
    end
    rst   = 1'b1;
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    capture(4);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (tr[i] !== 4'b0000) begin
        n_fail++;
        $display("FAIL midgap_after_rst cycle %0d: got %b expected 0000", i, tr[i]);
      end
    end
    pulse_start(4'd1, 4'd0);
    capture(9);
    for (int i = 0; i < 7; i++) ex[i] = {pat[6-i], 3'b110};
    ex[7] = 4'b0011;
    ex[8] = 4'b0000;
    for (int i = 0; i < 9; i++) begin
      n_checks++;
      if (tr[i] !== ex[i]) begin
        n_fail++;
        $display("FAIL post_rst_frame cycle %0d: got %b expected %b", i, tr[i], ex[i]);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    pat   = 7'b1100111;
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    reps  = 4'd0;
    gap   = 4'd0;
    @(negedge clk);
    test_reset;
    test_single;
    test_back_to_back;
    test_gap;
    test_zero_reps;
    test_abort;
    test_reset_midgap;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
